pulse_sequencer: RTL

//   Initiator side of the Doppler front-end control interface. Drives txEnable,

---
 rtl/seq_pkg.sv | 18 +
 rtl/seq_down_counter.sv | 32 +++
 rtl/pulse_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared state encoding and default widths for the pulse sequencer.
package seq_pkg;

    localparam int DEF_ADC_W   = 14;
    localparam int DEF_BURST_W = 8;
    localparam int DEF_DELAY_W = 16;
    localparam int DEF_WIN_W   = 12;
    localparam int DEF_PRP_W   = 20;

    typedef enum logic [2:0] {
        IDLE,
        TX,
        DLY,
        RX,
        WAIT
    } seq_state_e;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with zero and last-count flags; holds once it reaches zero.
module seq_down_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero,
    output logic         last
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && !zero) begin
            cnt <= cnt - ONE;
        end
    end

    assign zero = (cnt == '0);
    // Phases end on their last counted cycle; a zero load still yields one cycle.
    assign last = (cnt <= ONE);

endmodule

// File: rtl/pulse_sequencer.sv
// Frame sequencer for the Doppler front end: burst, range-gate delay, receive window
// and idle per pulse-repetition period, with gated sample forwarding to the DSP.
//
// state | meaning
// IDLE  | no frame in progress; run=1 latches config and starts a frame
// TX    | burst phase, txEnable high while burst count remains
// DLY   | range-gate delay, all enables low
// RX    | receive window, rxReady samples forwarded until win_len captured
// WAIT  | idle remainder of the PRP
module pulse_sequencer
    import seq_pkg::*;
#(
    parameter int ADC_W   = DEF_ADC_W,
    parameter int BURST_W = DEF_BURST_W,
    parameter int DELAY_W = DEF_DELAY_W,
    parameter int WIN_W   = DEF_WIN_W,
    parameter int PRP_W   = DEF_PRP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [1:0]         cfg_freq,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [DELAY_W-1:0] gate_delay,
    input  logic [WIN_W-1:0]   win_len,
    input  logic [PRP_W-1:0]   prp_len,
    input  logic               rxReady,
    input  logic [ADC_W-1:0]   adcIn,
    output logic               txEnable,
    output logic               rxEnable,
    output logic [1:0]         freqSel,
    output logic               smp_valid,
    output logic [ADC_W-1:0]   smp_data,
    output logic               smp_last,
    output logic               frame_start,
    output logic               overrun,
    output logic               busy
);

    localparam logic [PRP_W-1:0] PRP_ONE = PRP_W'(1);

    seq_state_e       state, state_nxt;
    logic             start_frame, trunc, frame_done, fwd, expire;
    logic [PRP_W-1:0] prp_cnt, prp_lim;
    logic             b_zero, b_last, d_zero, d_last, w_zero, w_last;

    assign fwd    = (state == RX) && rxReady;
    assign expire = (prp_cnt == prp_lim);

    seq_down_counter #(.W(BURST_W)) u_burst (
        .clk(clk), .rst(rst), .load(start_frame), .en(state == TX),
        .load_val(burst_len), .zero(b_zero), .last(b_last)
    );

    seq_down_counter #(.W(DELAY_W)) u_delay (
        .clk(clk), .rst(rst), .load(start_frame), .en(state == DLY),
        .load_val(gate_delay), .zero(d_zero), .last(d_last)
    );

    seq_down_counter #(.W(WIN_W)) u_window (
        .clk(clk), .rst(rst), .load(start_frame), .en(fwd),
        .load_val(win_len), .zero(w_zero), .last(w_last)
    );

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        trunc       = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    start_frame = 1'b1;
                    state_nxt   = TX;
                end
            end
            TX: begin
                if (expire)
                    trunc = 1'b1;
                else if (b_last)
                    state_nxt = !d_zero ? DLY : (!w_zero ? RX : WAIT);
            end
            DLY: begin
                if (expire)
                    trunc = 1'b1;
                else if (d_last)
                    state_nxt = w_zero ? WAIT : RX;
            end
            RX: begin
                if (expire)
                    trunc = 1'b1;
                else if (fwd && w_last)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (expire)
                    frame_done = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        // Next frame re-latches config in the same cycle the current one ends.
        if (trunc || frame_done) begin
            if (run) begin
                start_frame = 1'b1;
                state_nxt   = TX;
            end else begin
                state_nxt   = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            prp_cnt     <= '0;
            prp_lim     <= '0;
            freqSel     <= '0;
            frame_start <= 1'b0;
            overrun     <= 1'b0;
            smp_valid   <= 1'b0;
            smp_data    <= '0;
            smp_last    <= 1'b0;
        end else begin
            state       <= state_nxt;
            frame_start <= start_frame;
            smp_valid   <= fwd;
            smp_last    <= fwd && w_last && !expire;
            if (fwd)
                smp_data <= adcIn;
            if (trunc)
                overrun <= 1'b1;
            if (start_frame) begin
                prp_cnt <= '0;
                prp_lim <= (prp_len == '0) ? '0 : prp_len - PRP_ONE;
                freqSel <= cfg_freq;
            end else if (state != IDLE) begin
                prp_cnt <= prp_cnt + PRP_ONE;
            end
        end
    end

    assign txEnable = (state == TX) && !b_zero;
    assign rxEnable = (state == RX);
    assign busy     = (state != IDLE);

endmodule
